// File: rtl/sw_pkg.sv
// Shared constants and encodings for the Smith-Waterman feeder and the aligner it drives.
package sw_pkg;

   localparam int DEF_LEN_REF         = 64;
   localparam int DEF_LEN_QUERY       = 48;
   localparam int DEF_WIDTH_SCORE     = 8;
   localparam int DEF_WIDTH_POS_REF   = 7;
   localparam int DEF_WIDTH_POS_QUERY = 6;
   localparam int DEF_TIMEOUT         = 255;

   typedef enum logic [1:0] {
      BASE_A = 2'd0,
      BASE_C = 2'd1,
      BASE_G = 2'd2,
      BASE_T = 2'd3
   } base_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/sw_feeder_if.sv
// Feeder-to-aligner link: base stream out, completion strobe and result back.
interface sw_feeder_if import sw_pkg::*; #(
   parameter int WIDTH_SCORE     = DEF_WIDTH_SCORE,
   parameter int WIDTH_POS_REF   = DEF_WIDTH_POS_REF,
   parameter int WIDTH_POS_QUERY = DEF_WIDTH_POS_QUERY
);

   // sw_valid marks one base pair per cycle with no backpressure; sw_finish is a
   // one-cycle strobe and sw_max/sw_pos_* are only meaningful in that same cycle.
   logic                       sw_valid;
   logic [1:0]                 sw_data_ref;
   logic [1:0]                 sw_data_query;
   logic                       sw_finish;
   logic [WIDTH_SCORE-1:0]     sw_max;
   logic [WIDTH_POS_REF-1:0]   sw_pos_ref;
   logic [WIDTH_POS_QUERY-1:0] sw_pos_query;

   modport master (
      output sw_valid, sw_data_ref, sw_data_query,
      input  sw_finish, sw_max, sw_pos_ref, sw_pos_query
   );

   modport slave (
      input  sw_valid, sw_data_ref, sw_data_query,
      output sw_finish, sw_max, sw_pos_ref, sw_pos_query
   );

endinterface

// File: rtl/sw_feeder.sv
// Buffers host-written reference/query bases, streams them to the aligner and
// captures its result (or a timeout) for the host.
module sw_feeder import sw_pkg::*; #(
   parameter int LEN_REF         = DEF_LEN_REF,
   parameter int LEN_QUERY       = DEF_LEN_QUERY,
   parameter int WIDTH_SCORE     = DEF_WIDTH_SCORE,
   parameter int WIDTH_POS_REF   = DEF_WIDTH_POS_REF,
   parameter int WIDTH_POS_QUERY = DEF_WIDTH_POS_QUERY,
   parameter int TIMEOUT         = DEF_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic                       wr_sel,
   input  logic [6:0]                 wr_addr,
   input  logic [1:0]                 wr_data,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output logic [WIDTH_SCORE-1:0]     res_max,
   output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
   output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
   output state_t                     state,
   sw_feeder_if.master                sw
);

   localparam int RW = $clog2(LEN_REF);
   localparam int QW = $clog2(LEN_QUERY);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [1:0]    ref_buf   [LEN_REF];
   logic [1:0]    query_buf [LEN_QUERY];
   logic [RW-1:0] beat;
   logic [RW-1:0] beat_nxt;
   logic [CW-1:0] wait_cnt;

   logic          wr_ref;
   logic          wr_query;
   logic [1:0]    first_ref;
   logic [1:0]    first_query;
   logic [1:0]    next_ref;
   logic [1:0]    next_query;

   always_comb begin
      wr_ref      = wr_en && !busy && !wr_sel && (32'(wr_addr) < LEN_REF);
      wr_query    = wr_en && !busy &&  wr_sel && (32'(wr_addr) < LEN_QUERY);
      // A write landing on index 0 in the start cycle must appear on beat 0.
      first_ref   = (wr_ref && (wr_addr[RW-1:0] == '0)) ? wr_data : ref_buf[0];
      first_query = (wr_query && (wr_addr[QW-1:0] == '0)) ? wr_data : query_buf[0];
      beat_nxt    = beat + 1'b1;
      next_ref    = ref_buf[beat_nxt];
      next_query  = (32'(beat_nxt) < LEN_QUERY) ? query_buf[beat_nxt[QW-1:0]] : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         beat             <= '0;
         wait_cnt         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         timeout          <= 1'b0;
         res_max          <= '0;
         res_pos_ref      <= '0;
         res_pos_query    <= '0;
         sw.sw_valid      <= 1'b0;
         sw.sw_data_ref   <= 2'b00;
         sw.sw_data_query <= 2'b00;
         for (int i = 0; i < LEN_REF; i++) ref_buf[i] <= 2'b00;
         for (int i = 0; i < LEN_QUERY; i++) query_buf[i] <= 2'b00;
      end else begin
         if (wr_ref) ref_buf[wr_addr[RW-1:0]] <= wr_data;
         if (wr_query) query_buf[wr_addr[QW-1:0]] <= wr_data;
         done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state            <= ST_STREAM;
                  busy             <= 1'b1;
                  timeout          <= 1'b0;
                  res_max          <= '0;
                  res_pos_ref      <= '0;
                  res_pos_query    <= '0;
                  beat             <= '0;
                  sw.sw_valid      <= 1'b1;
                  sw.sw_data_ref   <= first_ref;
                  sw.sw_data_query <= first_query;
               end
            end

            ST_STREAM: begin
               if (32'(beat) == LEN_REF - 1) begin
                  state            <= ST_WAIT;
                  wait_cnt         <= '0;
                  sw.sw_valid      <= 1'b0;
                  sw.sw_data_ref   <= 2'b00;
                  sw.sw_data_query <= 2'b00;
               end else begin
                  beat             <= beat_nxt;
                  sw.sw_data_ref   <= next_ref;
                  sw.sw_data_query <= next_query;
               end
            end

            ST_WAIT: begin
               // Finish takes priority over a timeout expiring in the same cycle.
               if (sw.sw_finish) begin
                  state         <= ST_DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  res_max       <= sw.sw_max;
                  res_pos_ref   <= sw.sw_pos_ref;
                  res_pos_query <= sw.sw_pos_query;
               end else if (32'(wait_cnt) == TIMEOUT - 1) begin
                  state   <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            ST_DONE: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sw_feeder.sv
// Directed-plus-random bench for sw_feeder with a buffer/stream reference model.
module tb_sw_feeder;
   import sw_pkg::*;

   localparam int LR  = 64;
   localparam int LQ  = 48;
   localparam int WS  = 8;
   localparam int WPR = 7;
   localparam int WPQ = 6;
   localparam int TO  = 255;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           wr_en = 1'b0;
   logic           wr_sel = 1'b0;
   logic [6:0]     wr_addr = '0;
   logic [1:0]     wr_data = '0;
   logic           start = 1'b0;
   logic           busy;
   logic           done;
   logic           timeout;
   logic [WS-1:0]  res_max;
   logic [WPR-1:0] res_pos_ref;
   logic [WPQ-1:0] res_pos_query;
   state_t         state;

   int n_checks = 0;
   int n_err = 0;

   logic [1:0] ref_m   [LR];
   logic [1:0] query_m [LQ];

   sw_feeder_if #(.WIDTH_SCORE(WS), .WIDTH_POS_REF(WPR), .WIDTH_POS_QUERY(WPQ)) sw ();

   sw_feeder #(
      .LEN_REF(LR), .LEN_QUERY(LQ), .WIDTH_SCORE(WS),
      .WIDTH_POS_REF(WPR), .WIDTH_POS_QUERY(WPQ), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
      .busy(busy), .done(done), .timeout(timeout), .res_max(res_max),
      .res_pos_ref(res_pos_ref), .res_pos_query(res_pos_query),
      .state(state), .sw(sw)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Buffer rule: only in-range addresses land; the caller guarantees the DUT is idle.
   function automatic void model_write(input logic sel, input logic [6:0] addr, input logic [1:0] data);
      if (!sel && int'(addr) < LR) ref_m[addr[5:0]] = data;
      else if (sel && int'(addr) < LQ) query_m[addr[5:0]] = data;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < LR; i++) ref_m[i] = 2'b00;
      for (int i = 0; i < LQ; i++) query_m[i] = 2'b00;
   endfunction

   task automatic host_write(input logic sel, input logic [6:0] addr, input logic [1:0] data);
      wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
      tick();
      wr_en = 1'b0;
      model_write(sel, addr, data);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " valid"}, sw.sw_valid, 0);
      check({tag, " dref"}, sw.sw_data_ref, 0);
      check({tag, " dqry"}, sw.sw_data_query, 0);
      check({tag, " state"}, state, ST_IDLE);
   endtask

   // fin_at = 0 means the aligner never finishes.
   task automatic run(input string tag, input int fin_at, input logic [WS-1:0] mx,
                      input logic [WPR-1:0] pr, input logic [WPQ-1:0] pq,
                      input bit wr0, input logic [1:0] wr0_data, input bit disturb);
      logic [3:0]     exp_q[$];
      logic [3:0]     e;
      bit             exp_to;
      logic [WS-1:0]  e_max;
      logic [WPR-1:0] e_pr;
      logic [WPQ-1:0] e_pq;
      exp_to = (fin_at == 0);
      e_max  = exp_to ? '0 : mx;
      e_pr   = exp_to ? '0 : pr;
      e_pq   = exp_to ? '0 : pq;
      start = 1'b1;
      if (wr0) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd0; wr_data = wr0_data;
         model_write(1'b0, 7'd0, wr0_data);
      end
      for (int k = 0; k < LR; k++) exp_q.push_back({ref_m[k], (k < LQ) ? query_m[k] : 2'b00});
      tick();
      start = 1'b0; wr_en = 1'b0;
      check({tag, " res cleared"}, res_max, 0);
      check({tag, " tmo cleared"}, timeout, 0);
      for (int k = 0; k < LR; k++) begin
         e = exp_q.pop_front();
         check($sformatf("%s b%0d valid", tag, k), sw.sw_valid, 1);
         check($sformatf("%s b%0d ref", tag, k), sw.sw_data_ref, e[3:2]);
         check($sformatf("%s b%0d qry", tag, k), sw.sw_data_query, e[1:0]);
         check($sformatf("%s b%0d busy", tag, k), busy, 1);
         sw.sw_finish = 1'($urandom_range(0, 1));
         sw.sw_max = WS'($urandom);
         if (disturb && k == 10) begin
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 7'd5; wr_data = 2'd3;
         end
         tick();
         start = 1'b0; wr_en = 1'b0;
      end
      sw.sw_finish = 1'b0;
      for (int w = 1; w <= TO; w++) begin
         check($sformatf("%s w%0d valid", tag, w), sw.sw_valid, 0);
         check($sformatf("%s w%0d busy", tag, w), busy, 1);
         check($sformatf("%s w%0d done", tag, w), done, 0);
         if (w == 1) begin
            check({tag, " wait dref"}, sw.sw_data_ref, 0);
            check({tag, " wait dqry"}, sw.sw_data_query, 0);
         end
         if (w == fin_at) begin
            sw.sw_finish = 1'b1; sw.sw_max = mx; sw.sw_pos_ref = pr; sw.sw_pos_query = pq;
         end else begin
            sw.sw_max = WS'($urandom); sw.sw_pos_ref = WPR'($urandom);
         end
         tick();
         sw.sw_finish = 1'b0;
         if (w == fin_at) break;
      end
      sw.sw_max = WS'($urandom); sw.sw_pos_ref = WPR'($urandom); sw.sw_pos_query = WPQ'($urandom);
      check({tag, " done"}, done, 1);
      check({tag, " busy@done"}, busy, 0);
      check({tag, " timeout"}, timeout, 32'(exp_to));
      check({tag, " res_max"}, res_max, e_max);
      check({tag, " res_pos_ref"}, res_pos_ref, e_pr);
      check({tag, " res_pos_query"}, res_pos_query, e_pq);
      start = 1'b1; sw.sw_finish = 1'b1;
      tick();
      start = 1'b0; sw.sw_finish = 1'b0;
      check_quiet({tag, " after done"});
      tick();
      check_quiet({tag, " idle"});
      check({tag, " res held"}, res_max, e_max);
      check({tag, " tmo held"}, timeout, 32'(exp_to));
   endtask

   task automatic abort_run(input string tag, input int cycles);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (cycles) tick();
      reset = 1'b1;
      tick();
      check_quiet(tag);
      check({tag, " tmo"}, timeout, 0);
      check({tag, " res_max"}, res_max, 0);
      check({tag, " res_pos_ref"}, res_pos_ref, 0);
      check({tag, " res_pos_query"}, res_pos_query, 0);
      reset = 1'b0;
      model_clear();
      tick();
   endtask

   initial begin
      sw.sw_finish = 1'b0; sw.sw_max = '0; sw.sw_pos_ref = '0; sw.sw_pos_query = '0;
      model_clear();

      // Reset and idle outputs
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_quiet($sformatf("idle%0d", i));
         check("idle tmo", timeout, 0);
         check("idle res_max", res_max, 0);
         check("idle res_pos_ref", res_pos_ref, 0);
         check("idle res_pos_query", res_pos_query, 0);
      end

      // Stray finish while idle
      sw.sw_finish = 1'b1;
      tick();
      sw.sw_finish = 1'b0;
      check_quiet("idle finish");

      // All-zero buffers, finish 10 cycles into WAIT
      run("zero", 10, 8'd96, 7'd64, 6'd48, 1'b0, 2'd0, 1'b0);

      // Aligner never finishes
      run("tmo", 0, 8'd77, 7'd3, 6'd4, 1'b0, 2'd0, 1'b0);

      // Random contents, random finish latency
      for (int i = 0; i < LR; i++) host_write(1'b0, 7'(i), 2'($urandom));
      for (int i = 0; i < LQ; i++) host_write(1'b1, 7'(i), 2'($urandom));
      run("rand1", $urandom_range(1, TO - 1), WS'($urandom), WPR'($urandom), WPQ'($urandom),
          1'b0, 2'd0, 1'b0);

      // Out-of-range writes must not alias into the buffers
      host_write(1'b1, 7'd50, 2'd3);
      host_write(1'b0, 7'd64, ~ref_m[0]);
      host_write(1'b1, 7'd96, ~query_m[32]);
      host_write(1'b1, 7'd127, ~query_m[63 - 48 + 32]);
      for (int i = 0; i < 8; i++) host_write(1'b0, 7'($urandom_range(0, LR - 1)), 2'($urandom));
      run("rand2", TO, WS'($urandom), WPR'($urandom), WPQ'($urandom), 1'b0, 2'd0, 1'b0);

      // Start and write during STREAM are ignored; old ref[5] persists
      host_write(1'b0, 7'd5, 2'd1);
      run("disturb", 1, 8'd200, 7'd10, 6'd20, 1'b0, 2'd0, 1'b1);
      run("retain", 3, 8'd5, 7'd6, 6'd7, 1'b0, 2'd0, 1'b0);

      // Write to ref[0] in the start cycle shows up on beat 0
      host_write(1'b0, 7'd0, 2'd1);
      host_write(1'b1, 7'd0, 2'd3);
      run("wr0", $urandom_range(1, 40), WS'($urandom), WPR'($urandom), WPQ'($urandom),
          1'b1, 2'd2, 1'b0);

      // Reset mid-STREAM at beat 20, then a run streams zeros
      abort_run("rst stream", 20);
      run("post rst", 5, 8'd11, 7'd22, 6'd33, 1'b0, 2'd0, 1'b0);

      // Reset mid-WAIT
      for (int i = 0; i < 6; i++) host_write(1'b1, 7'($urandom_range(0, LQ - 1)), 2'($urandom));
      abort_run("rst wait", LR + 5);
      run("post rst2", 2, 8'd1, 7'd2, 6'd3, 1'b0, 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/sw_feeder.md
SW_FEEDER -- requirements
Module: sw_feeder

Interface
REQ-001 SHALL have parameter LEN_REF, default 64, reference length in bases.
REQ-002 SHALL have parameter LEN_QUERY, default 48, query length in bases.
REQ-003 SHALL have parameters WIDTH_SCORE=8, WIDTH_POS_REF=7, WIDTH_POS_QUERY=6, matching the aligner result widths.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles allowed for aligner finish.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  host base write strobe.
REQ-008 wr_sel  in  1  0 = reference buffer, 1 = query buffer.
REQ-009 wr_addr  in  7  base index.
REQ-010 wr_data  in  2  base code.
REQ-011 start  in  1  host request to stream buffers and run one alignment.
REQ-012 busy  out  1  high in STREAM and WAIT.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 timeout  out  1  set with done when the aligner never finished; held until next start.
REQ-015 res_max / res_pos_ref / res_pos_query  out  WIDTH_SCORE / WIDTH_POS_REF / WIDTH_POS_QUERY  captured result, held until next start.
REQ-016 sw_valid  out  1  aligner valid.
REQ-017 sw_data_ref / sw_data_query  out  2 / 2  aligner input bases.
REQ-018 sw_finish  in  1  aligner finish.
REQ-019 sw_max / sw_pos_ref / sw_pos_query  in  WIDTH_SCORE / WIDTH_POS_REF / WIDTH_POS_QUERY  aligner result.

Function
REQ-020 SHALL implement FSM IDLE -> STREAM -> WAIT -> DONE -> IDLE.
REQ-021 IDLE: start=1 SHALL enter STREAM on the next edge and clear timeout and all res_* outputs.
REQ-022 STREAM: sw_valid SHALL be 1 for exactly LEN_REF consecutive cycles, with beat k = 0..LEN_REF-1.
REQ-023 Beat k: sw_data_ref SHALL equal ref[k]; sw_data_query SHALL equal query[k] for k < LEN_QUERY, else 2'b00.
REQ-024 After beat LEN_REF-1, sw_valid SHALL drop to 0 and sw_data_* to 0 on the next cycle, and the FSM SHALL enter WAIT.
REQ-025 Outside STREAM, sw_valid SHALL be 0.
REQ-026 WAIT: a wait counter SHALL increment each cycle.
REQ-027 WAIT: sw_finish=1 SHALL latch sw_max/sw_pos_ref/sw_pos_query into res_* and enter DONE.
REQ-028 WAIT: if the counter reaches TIMEOUT with no finish, SHALL set timeout=1, keep res_*=0, and enter DONE.
REQ-029 If sw_finish and the timeout condition occur on the same cycle, finish SHALL win.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE.
REQ-031 sw_finish in IDLE, STREAM or DONE SHALL be ignored.
REQ-032 Writes SHALL be accepted only when busy=0.
REQ-033 Writes with wr_sel=0 and wr_addr >= LEN_REF, or wr_sel=1 and wr_addr >= LEN_QUERY, SHALL be ignored.
REQ-034 start while busy=1 or in DONE SHALL be ignored.
REQ-035 wr_en with start in the same IDLE cycle: the write SHALL commit, and beat 0 SHALL reflect it.
REQ-036 Buffers SHALL retain contents across runs.

Reset
REQ-037 reset SHALL force IDLE and zero the wait and beat counters.
REQ-038 reset SHALL clear both buffers to 0.
REQ-039 reset SHALL drive busy, done, timeout, res_*, sw_valid and sw_data_* to 0 on the next edge, including mid-STREAM and mid-WAIT.

Structure
REQ-040 Package sw_pkg SHALL hold LEN_REF/LEN_QUERY defaults, the score/position widths, the base encoding (A=0, C=1, G=2, T=3) and the FSM state encoding, shared with the aligner.
REQ-041 SHALL be a single module with no sub-module; the two buffers are register arrays read by beat index.

Verification
REQ-042 Reset, then 5 idle cycles -> all outputs 0, busy=0.
REQ-043 Load ref all 0, query all 0, start; model asserts finish 10 cycles into WAIT with max=96, pos 64/48 -> sw_valid high 64 cycles starting 1 cycle after start; sw_data_query 0 on beats 48..63; done pulse 1 cycle; res_max=96, res_pos_ref=64, res_pos_query=48, timeout=0.
REQ-044 Same load, model never finishes -> after 255 WAIT cycles done=1, timeout=1, res_*=0.
REQ-045 During STREAM, pulse start and write ref[5]=3 -> no restart; next run beat 5 still carries old ref[5]; write query addr 50 in IDLE -> ignored.
REQ-046 Assert reset at beat 20 -> next cycle sw_valid=0, busy=0; a following run streams all-zero bases.
REQ-047 Write ref[0]=2 in the same cycle as start -> beat 0 sw_data_ref=2.
